// File: rtl/vga_frame_capture.sv
// vga_frame_capture: sink-side VGA timing recovery. It registers the incoming
// syncs and RGB, re-derives h/v counters from the sync edges, checks the sync
// stream against the configured mode, locks once a full conforming frame has
// been seen, and emits visible pixels with Column/Row and a valid strobe.
// Optional feature: define VGA_CAPTURE_CRC_EN to compute a per-frame
// CRC-16-CCITT over the visible pixels on frame_crc (tied to 0 otherwise).
module vga_frame_capture #(
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic        pxclk,
    input  logic        rst,
    input  logic        vga_h_sync,
    input  logic        vga_v_sync,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue,
    output logic [9:0]  Column,
    output logic [9:0]  Row,
    output logic        pix_valid,
    output logic [7:0]  pix_r,
    output logic [7:0]  pix_g,
    output logic [7:0]  pix_b,
    output logic        locked,
    output logic        frame_start,
    output logic        timing_err,
    output logic [15:0] frame_count,
    output logic [15:0] frame_crc
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
    localparam logic [9:0] H_START  = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_END    = 10'(H_SYNC + H_BACK + H_VISIBLE - 1);
    localparam logic [9:0] V_START  = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_END    = 10'(V_SYNC + V_BACK + V_VISIBLE - 1);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t      state_q, state_d;
    logic        hs_q, vs_q, hs_prev_q, vs_prev_q;
    logic [23:0] rgb_q, rgb_dly_q;
    logic [9:0]  h_cnt_q, h_cnt_d, hs_width_q, hs_width_d, v_cnt_q, v_cnt_d;
    logic        v_arm_q, v_arm_d;
    logic        timing_err_q, timing_err_d;
    logic        pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
    logic [9:0]  column_q, column_d, row_q, row_d;
    logic [23:0] pix_q, pix_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        hs_edge, hs_fall, vs_edge, line0, chk_fail;
    logic [9:0]  col, row;

    assign hs_edge  = (hs_q == SYNC_ACTIVE) && (hs_prev_q != SYNC_ACTIVE);
    assign hs_fall  = (hs_q != SYNC_ACTIVE) && (hs_prev_q == SYNC_ACTIVE);
    assign vs_edge  = (vs_q == SYNC_ACTIVE) && (vs_prev_q != SYNC_ACTIVE);
    assign line0    = hs_edge && (v_arm_q || vs_edge);
    assign chk_fail = (hs_edge && (h_cnt_q != H_LAST)) ||
                      (hs_fall && (hs_width_q != H_SYNC_W)) ||
                      (line0 && (v_cnt_q != V_LAST));
    assign col      = h_cnt_q - H_START;
    assign row      = v_cnt_q - V_START;

    // Horizontal/vertical counters, hsync width and the vsync arm flag
    always_comb begin
        h_cnt_d    = hs_edge ? '0 : ((h_cnt_q == '1) ? h_cnt_q : h_cnt_q + 10'd1);
        hs_width_d = hs_width_q;
        if (hs_q == SYNC_ACTIVE) begin
            hs_width_d = hs_edge ? 10'd1 : ((hs_width_q == '1) ? hs_width_q : hs_width_q + 10'd1);
        end
        v_cnt_d = v_cnt_q;
        v_arm_d = v_arm_q;
        if (line0) begin
            v_cnt_d = '0;
            v_arm_d = 1'b0;
        end else begin
            if (vs_edge) v_arm_d = 1'b1;
            if (hs_edge) v_cnt_d = (v_cnt_q == '1) ? v_cnt_q : v_cnt_q + 10'd1;
        end
    end

    // Lock FSM next state; a failed check in VERIFY/LOCKED pulses timing_err
    always_comb begin
        state_d      = state_q;
        timing_err_d = 1'b0;
        case (state_q)
            SEARCH: if (line0) state_d = VERIFY;
            VERIFY: begin
                if (chk_fail) begin
                    state_d      = SEARCH;
                    timing_err_d = 1'b1;
                end else if (line0) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (chk_fail) begin
                    state_d      = SEARCH;
                    timing_err_d = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // Output stage; validity uses the next state so a failing edge blanks output at once
    always_comb begin
        pix_valid_d   = (state_d == LOCKED) && (h_cnt_q >= H_START) && (h_cnt_q <= H_END) &&
                        (v_cnt_q >= V_START) && (v_cnt_q <= V_END);
        column_d      = pix_valid_d ? col : '0;
        row_d         = pix_valid_d ? row : '0;
        pix_d         = pix_valid_d ? rgb_dly_q : '0;
        frame_start_d = pix_valid_d && (col == '0) && (row == '0);
        frame_count_d = frame_count_q;
        if (line0 && (state_q == LOCKED)) frame_count_d = frame_count_q + 16'd1;
    end

    // Lock FSM state register
    always_ff @(posedge pxclk) begin
        if (rst) state_q <= SEARCH;
        else     state_q <= state_d;
    end

    // Input stage, counters and output registers; rgb_dly_q re-aligns data with h_cnt_q
    always_ff @(posedge pxclk) begin
        if (rst) begin
            hs_q          <= ~SYNC_ACTIVE;
            vs_q          <= ~SYNC_ACTIVE;
            hs_prev_q     <= ~SYNC_ACTIVE;
            vs_prev_q     <= ~SYNC_ACTIVE;
            rgb_q         <= '0;
            rgb_dly_q     <= '0;
            h_cnt_q       <= '0;
            hs_width_q    <= '0;
            v_cnt_q       <= '0;
            v_arm_q       <= 1'b0;
            timing_err_q  <= 1'b0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            column_q      <= '0;
            row_q         <= '0;
            pix_q         <= '0;
            frame_count_q <= '0;
        end else begin
            hs_q          <= vga_h_sync;
            vs_q          <= vga_v_sync;
            hs_prev_q     <= hs_q;
            vs_prev_q     <= vs_q;
            rgb_q         <= {red, green, blue};
            rgb_dly_q     <= rgb_q;
            h_cnt_q       <= h_cnt_d;
            hs_width_q    <= hs_width_d;
            v_cnt_q       <= v_cnt_d;
            v_arm_q       <= v_arm_d;
            timing_err_q  <= timing_err_d;
            pix_valid_q   <= pix_valid_d;
            frame_start_q <= frame_start_d;
            column_q      <= column_d;
            row_q         <= row_d;
            pix_q         <= pix_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign Column      = column_q;
    assign Row         = row_q;
    assign pix_valid   = pix_valid_q;
    assign pix_r       = pix_q[23:16];
    assign pix_g       = pix_q[15:8];
    assign pix_b       = pix_q[7:0];
    assign locked      = (state_q == LOCKED);
    assign frame_start = frame_start_q;
    assign timing_err  = timing_err_q;
    assign frame_count = frame_count_q;

`ifdef VGA_CAPTURE_CRC_EN
    logic [15:0] crc_q, crc_d, frame_crc_q, frame_crc_d;

    function automatic logic [15:0] crc16_word(input logic [15:0] crc_in, input logic [23:0] word);
        logic [15:0] c;
        c = crc_in;
        for (int unsigned i = 0; i < 24; i++) begin
            if (c[15] ^ word[23 - i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                      c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // Running CRC restarts on the Column 0/Row 0 pixel; latched when a locked frame ends
    always_comb begin
        crc_d       = crc_q;
        frame_crc_d = frame_crc_q;
        if (pix_valid_d) crc_d = crc16_word(frame_start_d ? 16'hFFFF : crc_q, rgb_dly_q);
        if (line0 && (state_q == LOCKED)) frame_crc_d = crc_q;
    end

    // CRC registers
    always_ff @(posedge pxclk) begin
        if (rst) begin
            crc_q       <= '1;
            frame_crc_q <= '0;
        end else begin
            crc_q       <= crc_d;
            frame_crc_q <= frame_crc_d;
        end
    end

    assign frame_crc = frame_crc_q;
`else
    assign frame_crc = '0;
`endif

endmodule

// File: tb/tb_vga_frame_capture.sv
// tb_vga_frame_capture: directed bench for vga_frame_capture using a reduced
// video mode (8x4 visible, 15x9 total) so full frames stay short.
module tb_vga_frame_capture;

    localparam int HV = 8, HF = 2, HS = 3, HB = 2, HT = HV + HF + HS + HB;
    localparam int VV = 4, VF = 1, VS = 2, VB = 2, VT = VV + VF + VS + VB;
    localparam logic SA = 1'b0;

    logic        pxclk = 1'b0;
    logic        rst = 1'b1;
    logic        vga_h_sync = ~SA;
    logic        vga_v_sync = ~SA;
    logic [7:0]  red = '0, green = '0, blue = '0;
    logic [9:0]  Column, Row;
    logic        pix_valid, locked, frame_start, timing_err;
    logic [7:0]  pix_r, pix_g, pix_b;
    logic [15:0] frame_count, frame_crc;

    int checks = 0;
    int failures = 0;
    int pat = 0;   // 0: gradient, 1: black, 2: black with one red bit set

    int unsigned tick = 0;
    int unsigned fs_tick = 0;
    int pv_count = 0, fs_count = 0, te_count = 0, bad_px = 0, bad_idle = 0;
    logic [7:0] fs_r = '0, fs_g = '0, fs_b = '0;
    logic [9:0] fs_col = '0, fs_row = '0;

    vga_frame_capture #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE(SA)
    ) dut (
        .pxclk(pxclk), .rst(rst),
        .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
        .red(red), .green(green), .blue(blue),
        .Column(Column), .Row(Row), .pix_valid(pix_valid),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .locked(locked), .frame_start(frame_start), .timing_err(timing_err),
        .frame_count(frame_count), .frame_crc(frame_crc)
    );

    always #5 pxclk = ~pxclk;

    always @(posedge pxclk) tick <= tick + 1;

    // Output monitor, sampled on the falling edge
    always @(negedge pxclk) begin
        if (pix_valid) begin
            pv_count++;
            if (pat == 0 && (pix_r !== Column[7:0] || pix_g !== Row[7:0] || pix_b !== 8'h5A)) bad_px++;
        end else if ({Column, Row, pix_r, pix_g, pix_b} !== 44'd0 || frame_start !== 1'b0) begin
            bad_idle++;
        end
        if (frame_start === 1'b1) begin
            fs_count++;
            fs_tick = tick;
            fs_r = pix_r; fs_g = pix_g; fs_b = pix_b;
            fs_col = Column; fs_row = Row;
        end
        if (timing_err === 1'b1) te_count++;
    end

    task automatic cyc(input logic hs, input logic vs, input logic [23:0] rgb);
        @(negedge pxclk);
        vga_h_sync = hs;
        vga_v_sync = vs;
        {red, green, blue} = rgb;
    endtask

    task automatic drive_pix(input int l, input int p, input int hs_w);
        int row, col;
        logic [23:0] rgb;
        row = l - (VS + VB);
        col = p - (HS + HB);
        rgb = 24'hEEEEEE;
        if (row >= 0 && row < VV && col >= 0 && col < HV) begin
            case (pat)
                0:       rgb = {col[7:0], row[7:0], 8'h5A};
                1:       rgb = 24'h000000;
                default: rgb = (row == 1 && col == 2) ? 24'h010000 : 24'h000000;
            endcase
        end
        cyc((p < hs_w) ? SA : ~SA, (l < VS) ? SA : ~SA, rgb);
    endtask

    task automatic drive_line(input int l, input int hs_w, input int len);
        for (int p = 0; p < len; p++) drive_pix(l, p, hs_w);
    endtask

    task automatic drive_lines(input int first, input int last);
        for (int l = first; l <= last; l++) drive_line(l, HS, HT);
    endtask

    function automatic logic [15:0] crc_model(input int flip);
        logic [15:0] c;
        logic [23:0] w;
        logic fb;
        c = 16'hFFFF;
        for (int px = 0; px < HV * VV; px++) begin
            w = (flip != 0 && px == HV + 2) ? 24'h010000 : 24'h000000;
            for (int b = 23; b >= 0; b--) begin
                fb = c[15] ^ w[b];
                c = c << 1;
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    task automatic test_reset();
        repeat (4) cyc(~SA, ~SA, 24'h0);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked: got %b want 0", locked); end
        checks++; if (pix_valid !== 1'b0 || frame_start !== 1'b0 || timing_err !== 1'b0) begin
            failures++; $display("FAIL reset_strobes: got pv=%b fs=%b te=%b want 0", pix_valid, frame_start, timing_err); end
        checks++; if ({Column, Row, pix_r, pix_g, pix_b} !== 44'd0) begin
            failures++; $display("FAIL reset_pixel: got col=%0d row=%0d rgb=%h%h%h want 0", Column, Row, pix_r, pix_g, pix_b); end
        checks++; if (frame_count !== 16'd0 || frame_crc !== 16'd0) begin
            failures++; $display("FAIL reset_counters: got fc=%0d crc=%h want 0", frame_count, frame_crc); end
        rst = 1'b0;
    endtask

    task automatic test_lock();
        int pv0, fs0;
        drive_lines(0, VT - 1);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL lock_early: got %b want 0", locked); end
        pv0 = pv_count; fs0 = fs_count;
        drive_lines(0, 0);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lock_after_frame: got %b want 1", locked); end
        drive_lines(1, VT - 1);
        checks++; if (pv_count - pv0 != HV * VV) begin failures++; $display("FAIL pix_valid_count: got %0d want %0d", pv_count - pv0, HV * VV); end
        checks++; if (fs_count - fs0 != 1) begin failures++; $display("FAIL frame_start_count: got %0d want 1", fs_count - fs0); end
        checks++; if ({fs_r, fs_g, fs_b} !== 24'h00005A) begin failures++; $display("FAIL first_pixel: got %h%h%h want 00005a", fs_r, fs_g, fs_b); end
        checks++; if ({fs_col, fs_row} !== 20'd0) begin failures++; $display("FAIL first_coord: got col=%0d row=%0d want 0,0", fs_col, fs_row); end
        checks++; if (bad_px != 0) begin failures++; $display("FAIL pixel_data: got %0d bad pixels want 0", bad_px); end
        checks++; if (te_count != 0) begin failures++; $display("FAIL spurious_err: got %0d pulses want 0", te_count); end
        checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL frame_count_lock: got %0d want 0", frame_count); end
    endtask

    task automatic test_simultaneous();
        int unsigned t0, exp_tick;
        drive_pix(0, 0, HS);
        t0 = tick;
        for (int p = 1; p < HT; p++) drive_pix(0, p, HS);
        drive_lines(1, VT - 1);
        exp_tick = t0 + 1 + (VS + VB) * HT + HS + HB + 2;
        checks++; if (fs_tick != exp_tick) begin failures++; $display("FAIL row0_latency: got tick %0d want %0d", fs_tick, exp_tick); end
        checks++; if (frame_count !== 16'd1) begin failures++; $display("FAIL frame_count_inc: got %0d want 1", frame_count); end
    endtask

    task automatic test_short_line();
        int pv0, te0;
        pv0 = pv_count; te0 = te_count;
        drive_lines(0, 4);
        drive_line(5, HS, HT - 1);
        drive_lines(6, VT - 1);
        checks++; if (te_count - te0 != 1) begin failures++; $display("FAIL short_err_pulse: got %0d want 1", te_count - te0); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL short_unlock: got %b want 0", locked); end
        checks++; if (pv_count - pv0 != 2 * HV) begin failures++; $display("FAIL short_pix_valid: got %0d want %0d", pv_count - pv0, 2 * HV); end
        checks++; if (frame_count !== 16'd2) begin failures++; $display("FAIL short_frame_count: got %0d want 2", frame_count); end
        drive_lines(0, VT - 1);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL relock_early: got %b want 0", locked); end
        drive_lines(0, 0);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL relock: got %b want 1", locked); end
        drive_lines(1, VT - 1);
        checks++; if (bad_idle != 0) begin failures++; $display("FAIL idle_outputs: got %0d nonzero samples want 0", bad_idle); end
    endtask

    task automatic test_mid_reset();
        drive_lines(0, 5);
        for (int p = 0; p <= 8; p++) drive_pix(6, p, HS);
        checks++; if (pix_valid !== 1'b1 || frame_count !== 16'd3) begin
            failures++; $display("FAIL pre_reset: got pv=%b fc=%0d want 1,3", pix_valid, frame_count); end
        rst = 1'b1;
        drive_pix(6, 9, HS);
        checks++; if (locked !== 1'b0 || pix_valid !== 1'b0 || frame_count !== 16'd0) begin
            failures++; $display("FAIL mid_reset: got lk=%b pv=%b fc=%0d want 0,0,0", locked, pix_valid, frame_count); end
        checks++; if ({Column, Row, pix_r, pix_g, pix_b} !== 44'd0 || frame_crc !== 16'd0) begin
            failures++; $display("FAIL mid_reset_pixel: got col=%0d row=%0d crc=%h want 0", Column, Row, frame_crc); end
        rst = 1'b0;
        for (int p = 10; p < HT; p++) drive_pix(6, p, HS);
        drive_lines(7, VT - 1);
        drive_lines(0, VT - 1);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_relock_early: got %b want 0", locked); end
        drive_lines(0, 0);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL reset_relock: got %b want 1", locked); end
        drive_lines(1, VT - 1);
        checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
    endtask

    task automatic test_hsync_width();
        int te0;
        rst = 1'b1;
        cyc(~SA, ~SA, 24'h0);
        rst = 1'b0;
        te0 = te_count;
        drive_lines(0, 2);
        drive_line(3, HS - 1, HT);
        drive_lines(4, VT - 1);
        checks++; if (te_count - te0 != 1) begin failures++; $display("FAIL width_err_pulse: got %0d want 1", te_count - te0); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL width_locked: got %b want 0", locked); end
        drive_lines(0, 0);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL width_search: got %b want 0", locked); end
        drive_lines(1, VT - 1);
        drive_lines(0, 0);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL width_relock: got %b want 1", locked); end
        drive_lines(1, VT - 1);
    endtask

`ifdef VGA_CAPTURE_CRC_EN
    task automatic test_crc();
        logic [15:0] exp_black, exp_flip;
        exp_black = crc_model(0);
        exp_flip  = crc_model(1);
        pat = 1;
        drive_lines(0, VT - 1);
        drive_lines(0, 0);
        checks++; if (frame_crc !== exp_black) begin failures++; $display("FAIL crc_black: got %h want %h", frame_crc, exp_black); end
        drive_lines(1, VT - 1);
        pat = 2;
        drive_lines(0, 0);
        checks++; if (frame_crc !== exp_black) begin failures++; $display("FAIL crc_repeat: got %h want %h", frame_crc, exp_black); end
        drive_lines(1, VT - 1);
        pat = 0;
        drive_lines(0, 0);
        checks++; if (frame_crc !== exp_flip) begin failures++; $display("FAIL crc_flip: got %h want %h", frame_crc, exp_flip); end
        checks++; if (frame_crc === exp_black) begin failures++; $display("FAIL crc_flip_differs: got %h want not %h", frame_crc, exp_black); end
        drive_lines(1, VT - 1);
    endtask
`else
    task automatic test_crc();
        drive_lines(0, VT - 1);
        drive_lines(0, 0);
        checks++; if (frame_crc !== 16'd0) begin failures++; $display("FAIL crc_absent: got %h want 0000", frame_crc); end
        checks++; if (frame_count !== 16'd2) begin failures++; $display("FAIL frame_count_run: got %0d want 2", frame_count); end
        drive_lines(1, VT - 1);
    endtask
`endif

    initial begin
        test_reset();
        test_lock();
        test_simultaneous();
        test_short_line();
        test_mid_reset();
        test_hsync_width();
        test_crc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
